// File: rtl/dsp_t1_mode_bits_loader.sv
// Byte-stream loader for the 93-bit DSP mode word.
// Bytes collect in a shadow register and reach the cfg outputs only through one atomic commit.
module dsp_t1_mode_bits_loader #(
    parameter bit AUTO_COMMIT     = 1'b1,
    parameter bit CHECK_FRACTURED = 1'b1
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        commit_i,
    input  logic        abort_i,
    output logic [79:0] coeff_o,
    output logic        f_mode_o,
    output logic [2:0]  output_select_o,
    output logic        saturate_enable_o,
    output logic [5:0]  shift_right_o,
    output logic        round_o,
    output logic        register_inputs_o,
    output logic        cfg_valid_o,
    output logic        cfg_update_o,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, SHIFT, PENDING, COMMIT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  byteCnt_q, byteCnt_d;
    logic [92:0] shadow_q, shadow_d;
    logic [92:0] cfg_q, cfg_d;
    logic        cfgValid_q, cfgValid_d;
    logic        update_q, update_d;
    logic        err_q, err_d;

    logic        abortHit;
    logic        accept;
    logic [92:0] wordFull;
    logic        fracBad;
    logic        wordBad;

    assign ready_o  = reset_n_i && ((state_q == IDLE) || (state_q == SHIFT));
    assign abortHit = abort_i && ((state_q == SHIFT) || (state_q == PENDING));
    assign accept   = valid_i && ready_o && !abortHit;

    // The word as it will look once the byte on data_i (byte 11) lands.
    assign wordFull = {data_i[4:0], shadow_q[87:0]};

    always_comb begin
        fracBad = 1'b0;
        for (int n = 0; n < 4; n++) begin
            if (wordFull[20*n+10 +: 10] != 10'd0) fracBad = 1'b1;
        end
        wordBad = (data_i[7:5] != 3'd0) || (CHECK_FRACTURED && wordFull[80] && fracBad);
    end

    always_comb begin
        state_d    = state_q;
        byteCnt_d  = byteCnt_q;
        shadow_d   = shadow_q;
        cfg_d      = cfg_q;
        cfgValid_d = cfgValid_q;
        update_d   = 1'b0;
        err_d      = 1'b0;

        if (accept) begin
            if (byteCnt_q == 4'd11) shadow_d[92:88] = data_i[4:0];
            else                    shadow_d[{byteCnt_q, 3'b000} +: 8] = data_i;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SHIFT;
                    byteCnt_d = 4'd1;
                end
            end
            SHIFT: begin
                if (abortHit) begin
                    state_d   = IDLE;
                    byteCnt_d = 4'd0;
                end else if (accept) begin
                    if (byteCnt_q == 4'd11) begin
                        byteCnt_d = 4'd0;
                        if (wordBad) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = PENDING;
                        end
                    end else begin
                        byteCnt_d = byteCnt_q + 4'd1;
                    end
                end
            end
            PENDING: begin
                if (abortHit)                     state_d = IDLE;
                else if (AUTO_COMMIT || commit_i) state_d = COMMIT;
            end
            COMMIT: begin
                cfg_d      = shadow_q;
                update_d   = 1'b1;
                cfgValid_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            byteCnt_q  <= 4'd0;
            shadow_q   <= '0;
            cfg_q      <= '0;
            cfgValid_q <= 1'b0;
            update_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byteCnt_q  <= byteCnt_d;
            shadow_q   <= shadow_d;
            cfg_q      <= cfg_d;
            cfgValid_q <= cfgValid_d;
            update_q   <= update_d;
            err_q      <= err_d;
        end
    end

    assign coeff_o           = cfg_q[79:0];
    assign f_mode_o          = cfg_q[80];
    assign output_select_o   = cfg_q[83:81];
    assign saturate_enable_o = cfg_q[84];
    assign shift_right_o     = cfg_q[90:85];
    assign round_o           = cfg_q[91];
    assign register_inputs_o = cfg_q[92];
    assign cfg_valid_o       = cfgValid_q;
    assign cfg_update_o      = update_q;
    assign busy_o            = (state_q != IDLE);
    assign err_o             = err_q;

endmodule
